// File: rtl/prog_loader.sv
// prog_loader: assembles a little-endian byte stream into 16-bit words, writes them to
// instruction memory and holds the core in reset until loaded. Trailer checksum: PROG_LOADER_CHECKSUM_EN.
module prog_loader #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   load_len,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              cpu_rst,
`ifdef PROG_LOADER_CHECKSUM_EN
    output logic [15:0]       csum,
    output logic              csum_err,
`endif
    output logic [ADDR_W:0]   word_count
);

    localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(DEPTH);

`ifdef PROG_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_IDLE, S_LO, S_HI, S_WRITE, S_DONE, S_CK_LO, S_CK_HI, S_ERR
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_LO, S_HI, S_WRITE, S_DONE
    } state_t;
`endif

    state_t            r_state;
    state_t            w_state_nxt;
    state_t            w_fin;
    logic [ADDR_W:0]   r_len;
    logic [ADDR_W:0]   r_word_count;
    logic [ADDR_W:0]   w_len_in;
    logic [ADDR_W:0]   w_count_inc;
    logic [7:0]        r_lo;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [15:0]       r_mem_wdata;
    logic              w_start_ok;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [15:0]       r_csum;
`endif

    assign w_len_in    = (load_len > LP_DEPTH) ? LP_DEPTH : load_len;
    assign w_count_inc = r_word_count + 1'b1;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign word_count  = r_word_count;

    // After the final word the load either completes or collects the checksum trailer.
`ifdef PROG_LOADER_CHECKSUM_EN
    assign w_fin = S_CK_LO;
    assign csum  = r_csum;
`else
    assign w_fin = S_DONE;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        mem_we      = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        cpu_rst     = 1'b1;
        w_start_ok  = 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
        csum_err    = 1'b0;
`endif
        case (r_state)
            S_IDLE: w_start_ok = start;
            S_DONE: begin
                done       = 1'b1;
                cpu_rst    = 1'b0;
                w_start_ok = start;
            end
            S_LO: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid) w_state_nxt = S_HI;
            end
            S_HI: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid) w_state_nxt = S_WRITE;
            end
            S_WRITE: begin
                busy        = 1'b1;
                mem_we      = 1'b1;
                w_state_nxt = (w_count_inc == r_len) ? w_fin : S_LO;
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            S_CK_LO: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid) w_state_nxt = S_CK_HI;
            end
            S_CK_HI: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid) w_state_nxt = ({in_data, r_lo} == r_csum) ? S_DONE : S_ERR;
            end
            S_ERR: begin
                csum_err   = 1'b1;
                w_start_ok = start;
            end
`endif
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_start_ok) w_state_nxt = (w_len_in == '0) ? w_fin : S_LO;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_len        <= '0;
            r_word_count <= '0;
            r_lo         <= '0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
            r_csum       <= '0;
`endif
        end else begin
            if (w_start_ok) begin
                r_len        <= w_len_in;
                r_word_count <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
                r_csum       <= '0;
`endif
            end
            if (r_state == S_LO && in_valid) r_lo <= in_data;
            // Address/data are captured on the high-byte handshake so they hold between writes.
            if (r_state == S_HI && in_valid) begin
                r_mem_addr  <= r_word_count[ADDR_W-1:0];
                r_mem_wdata <= {in_data, r_lo};
            end
            if (r_state == S_WRITE) begin
                r_word_count <= w_count_inc;
`ifdef PROG_LOADER_CHECKSUM_EN
                r_csum       <= r_csum + r_mem_wdata;
`endif
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            if (r_state == S_CK_LO && in_valid) r_lo <= in_data;
`endif
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed and randomized loads checked against a queue-based image model.
// Checksum scenarios compile in when PROG_LOADER_CHECKSUM_EN is defined.
module tb_prog_loader;

    localparam int ADDR_W = 8;
    localparam int DEPTH  = 256;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W:0]   load_len;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata;
    logic              busy;
    logic              done;
    logic              cpu_rst;
    logic [ADDR_W:0]   word_count;
    logic              err_sig;
    logic [15:0]       csum_sig;

    prog_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .load_len   (load_len),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .busy       (busy),
        .done       (done),
        .cpu_rst    (cpu_rst),
`ifdef PROG_LOADER_CHECKSUM_EN
        .csum       (csum_sig),
        .csum_err   (err_sig),
`endif
        .word_count (word_count)
    );

`ifndef PROG_LOADER_CHECKSUM_EN
    assign err_sig  = 1'b0;
    assign csum_sig = 16'h0;
`endif

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc   = 0;
    logic [7:0]  bytes[$];
    logic [23:0] obs_q[$];
    int          wcyc_q[$];
    bit          saw_ready;
    bit          have_last = 0;
    logic [7:0]  last_addr;
    logic [15:0] last_data;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Write monitor; also enforces that address/data hold while no write is issued.
    always @(negedge clk) begin
        if (rst) begin
            have_last = 0;
        end else begin
            if (in_ready) saw_ready = 1;
            if (mem_we) begin
                obs_q.push_back({mem_addr, mem_wdata});
                wcyc_q.push_back(cyc);
                last_addr = mem_addr;
                last_data = mem_wdata;
                have_last = 1;
            end else if (have_last) begin
                check("hold_addr", 32'(mem_addr), 32'(last_addr));
                check("hold_data", 32'(mem_wdata), 32'(last_data));
            end
        end
    end

    task automatic fill_random(input int nwords);
        bytes.delete();
        for (int i = 0; i < 2 * nwords; i++) bytes.push_back(8'($urandom));
    endtask

    task automatic add_trailer(input bit corrupt);
`ifdef PROG_LOADER_CHECKSUM_EN
        int unsigned sum = 0;
        for (int i = 0; i + 1 < bytes.size(); i += 2) sum += {bytes[i+1], bytes[i]};
        bytes.push_back(8'(sum) ^ {7'd0, corrupt});
        bytes.push_back(8'(sum >> 8));
`else
        if (corrupt) bytes.push_back(8'h00);
`endif
    endtask

    task automatic check_reset_outputs();
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_mem_we", 32'(mem_we), 0);
        check("rst_mem_addr", 32'(mem_addr), 0);
        check("rst_mem_wdata", 32'(mem_wdata), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_cpu_rst", 32'(cpu_rst), 1);
        check("rst_word_count", 32'(word_count), 0);
`ifdef PROG_LOADER_CHECKSUM_EN
        check("rst_csum", 32'(csum_sig), 0);
        check("rst_csum_err", 32'(err_sig), 0);
`endif
    endtask

    task automatic run_load(input int len_req, input int pct, input bit toggle,
                            input bit poke_start, input int abort_idx,
                            output int exit_cyc, output int iters);
        int n;
        int idx = 0;
        int budget;
        bit hs = 1;
        bit poked = 0;
        bit exp_done0;
        n = (len_req > DEPTH) ? DEPTH : len_req;
        obs_q.delete();
        wcyc_q.delete();
        saw_ready = 0;
        iters = 0;
        @(posedge clk); #1;
        start = 1'b1;
        load_len = 9'(len_req);
        in_valid = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
        exp_done0 = 0;
`else
        exp_done0 = (n == 0);
`endif
        check("start_done", 32'(done), 32'(exp_done0));
        check("start_cpu_rst", 32'(cpu_rst), 32'(!exp_done0));
        budget = 40 * bytes.size() + 20;
        while (!done && !err_sig && budget > 0) begin
            if (abort_idx >= 0 && idx == abort_idx) break;
            if (idx < bytes.size()) begin
                if (toggle) in_valid = ~in_valid;
                else if (hs || !in_valid) in_valid = ($urandom_range(99) < pct);
                in_data = bytes[idx];
            end else begin
                in_valid = 1'b0;
            end
            if (poke_start && !poked && in_ready && (idx % 2 == 1)) begin
                start = 1'b1;
                load_len = 9'd1;
                poked = 1;
            end
            @(negedge clk);
            hs = in_valid && in_ready;
            @(posedge clk); #1;
            start = 1'b0;
            if (hs) idx++;
            budget--;
            iters++;
        end
        in_valid = 1'b0;
        exit_cyc = cyc;
        if (abort_idx < 0) check("load_in_budget", 32'(budget > 0), 1);
    endtask

    task automatic check_load(input int len_req, input bit exp_err);
        int n;
        int unsigned sum = 0;
        logic [23:0] e;
        n = (len_req > DEPTH) ? DEPTH : len_req;
        check("write_count", 32'(obs_q.size()), 32'(n));
        for (int i = 0; i < n && i < obs_q.size(); i++) begin
            e = {8'(i), bytes[2*i+1], bytes[2*i]};
            sum += {bytes[2*i+1], bytes[2*i]};
            check("write_entry", 32'(obs_q[i]), 32'(e));
        end
        check("end_word_count", 32'(word_count), 32'(n));
        check("end_done", 32'(done), 32'(!exp_err));
        check("end_cpu_rst", 32'(cpu_rst), 32'(exp_err));
        check("end_busy", 32'(busy), 0);
        check("end_in_ready", 32'(in_ready), 0);
`ifdef PROG_LOADER_CHECKSUM_EN
        check("end_csum", 32'(csum_sig), 32'(16'(sum)));
        check("end_csum_err", 32'(err_sig), 32'(exp_err));
`endif
    endtask

    initial begin
        int ec;
        int it;
        int len;
        rst = 1'b1;
        start = 1'b0;
        load_len = '0;
        in_valid = 1'b0;
        in_data = '0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs();
        rst = 1'b0;

        // Zero-length load: straight to DONE (or to the trailer when checksummed).
        bytes.delete();
        add_trailer(0);
        run_load(0, 100, 0, 0, -1, ec, it);
        check_load(0, 0);
        check("len0_never_ready", 32'(saw_ready), 32'(bytes.size() != 0));
`ifndef PROG_LOADER_CHECKSUM_EN
        check("len0_latency", 32'(it), 0);
`endif

        // Three words, streaming with no gaps.
        bytes = '{8'h34, 8'h12, 8'hCD, 8'hAB, 8'h01, 8'h00};
        add_trailer(0);
        run_load(3, 100, 0, 0, -1, ec, it);
        check_load(3, 0);
        if (wcyc_q.size() == 3) begin
            check("pulse_gap_1", 32'(wcyc_q[1] - wcyc_q[0]), 3);
            check("pulse_gap_2", 32'(wcyc_q[2] - wcyc_q[1]), 3);
`ifndef PROG_LOADER_CHECKSUM_EN
            check("done_after_last", 32'(ec - wcyc_q[2]), 1);
`endif
        end

        // Async reset while waiting for the high byte of the fourth word.
        fill_random(10);
        run_load(10, 100, 0, 0, 7, ec, it);
        check("pre_rst_writes", 32'(obs_q.size()), 3);
        #2 rst = 1'b1;
        #1 check_reset_outputs();
        @(posedge clk); #1;
        rst = 1'b0;
        fill_random(4);
        add_trailer(0);
        run_load(4, 70, 0, 0, -1, ec, it);
        check_load(4, 0);

        // Valid toggling every cycle with a start pulse during HI that must be ignored.
        fill_random(2);
        add_trailer(0);
        run_load(2, 100, 1, 1, -1, ec, it);
        check_load(2, 0);

        // Oversized request clamps to a full 256-word image.
        fill_random(DEPTH);
        add_trailer(0);
        run_load(300, 100, 0, 0, -1, ec, it);
        check_load(300, 0);

        for (int k = 0; k < 6; k++) begin
            len = $urandom_range(1, 12);
            fill_random(len);
            add_trailer(0);
            run_load(len, $urandom_range(30, 100), 0, 0, -1, ec, it);
            check_load(len, 0);
        end

`ifdef PROG_LOADER_CHECKSUM_EN
        bytes = '{8'h01, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00};
        run_load(2, 100, 0, 0, -1, ec, it);
        check_load(2, 0);
        bytes = '{8'h01, 8'h00, 8'hFF, 8'hFF, 8'h01, 8'h00};
        run_load(2, 100, 0, 0, -1, ec, it);
        check_load(2, 1);
        fill_random(3);
        add_trailer(0);
        run_load(3, 80, 0, 0, -1, ec, it);
        check_load(3, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
